// File: rtl/tx_wr_addr_update_arb_if.sv
// tx_wr_addr_update_arb_if: valid/ready address-update bus carrying channel index and address value.
interface tx_wr_addr_update_arb_if #(
    parameter int AW  = 10,
    parameter int CHW = 2
);
    logic           upd_valid;
    logic           upd_ready;
    logic [CHW-1:0] upd_ch;
    logic [AW-1:0]  upd_addr;

    modport master (output upd_valid, upd_ch, upd_addr, input upd_ready);
    modport slave  (input upd_valid, upd_ch, upd_addr, output upd_ready);
endinterface

// File: rtl/tx_wr_addr_update_arb.sv
// tx_wr_addr_update_arb: publishes changed per-channel committed write addresses one at a time,
// round-robin among eligible channels, with a per-channel hold-off that coalesces rapid changes.
module tx_wr_addr_update_arb #(
    parameter int NCH     = 4,
    parameter int AW      = 10,
    parameter int CHW     = 2,
    parameter int HOLDOFF = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NCH*AW-1:0]   addr_in,
    input  logic [NCH-1:0]      ch_enable,
    output logic [NCH*AW-1:0]   last_addr_out,
    tx_wr_addr_update_arb_if.master bus
);
    logic [NCH-1:0][AW-1:0] addr_v;
    logic [NCH-1:0][AW-1:0] last_pub;
    logic [NCH-1:0][7:0]    hcnt;
    logic [NCH-1:0]         elig;
    logic [CHW-1:0]         rr_ptr;
    logic [CHW-1:0]         gnt;
    logic [CHW-1:0]         idx;
    logic                   found;
    logic                   free;
    logic                   accept;

    assign addr_v        = addr_in;
    assign last_addr_out = last_pub;
    assign accept        = bus.upd_valid && bus.upd_ready;
    assign free          = !bus.upd_valid || bus.upd_ready;

    // The channel currently on the bus is excluded so a held update is never re-granted.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++)
            elig[i] = ch_enable[i] && addr_v[i] != last_pub[i] && hcnt[i] == 8'd0 &&
                      !(bus.upd_valid && bus.upd_ch == CHW'(i));
    end

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = CHW'((int'(rr_ptr) + k) % NCH);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.upd_valid <= 1'b0;
            bus.upd_ch    <= '0;
            bus.upd_addr  <= '0;
            last_pub      <= '0;
            hcnt          <= '0;
            rr_ptr        <= CHW'(NCH - 1);
        end else begin
            for (int i = 0; i < NCH; i++)
                if (accept && bus.upd_ch == CHW'(i))
                    hcnt[i] <= 8'(HOLDOFF);
                else if (hcnt[i] != 8'd0)
                    hcnt[i] <= hcnt[i] - 8'd1;
            if (free) begin
                bus.upd_valid <= found;
                if (found) begin
                    bus.upd_ch    <= gnt;
                    bus.upd_addr  <= addr_v[gnt];
                    last_pub[gnt] <= addr_v[gnt];
                    rr_ptr        <= gnt;
                end
            end
        end
    end
endmodule
